// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Optional invalid-digit flag enabled by defining BCD_SUB_INVALID_CHECK_EN.
module bcd_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is sampled only in IDLE; busy covers RUN and DONE;
    // done is a one-cycle pulse in DONE, and diff/bout/err hold until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_sh, b_sh, diff_r;
    logic            borrow, bout_r;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [3:0]      ad, bd, digit;
    logic [4:0]      t;
    logic            neg;
    logic [W+3:0]    cat;

    assign ad    = a_sh[3:0];
    assign bd    = b_sh[3:0];
    assign t     = {1'b0, ad} - {1'b0, bd} - {4'b0000, borrow};
    assign neg   = t[4];
    assign digit = neg ? (t[3:0] + 4'd10) : t[3:0];
    // New digit enters at the MSB end; written this way so DIGITS=1 needs no special case.
    assign cat   = {digit, diff_r};
    assign last  = (cnt == CW'(DIGITS - 1));

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            a_sh   <= a;
            b_sh   <= b;
            diff_r <= '0;
            borrow <= bin;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            diff_r <= cat[W+3:4];
            borrow <= neg;
            cnt    <= cnt + CW'(1);
            if (last) bout_r <= neg;
        end
    end

`ifdef BCD_SUB_INVALID_CHECK_EN
    logic err_r;

    always_ff @(posedge clk) begin
        if (rst)                          err_r <= 1'b0;
        else if (state == IDLE && start)  err_r <= 1'b0;
        else if (state == RUN && (ad > 4'd9 || bd > 4'd9)) err_r <= 1'b1;
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign diff      = diff_r;
    assign bout      = bout_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub (DIGITS=4): directed cases, handshake corners, random ops.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          bin = 1'b0;
  logic          busy, done, bout, err;
  logic [W-1:0]  diff;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_cnt = 0;

  // {err, bout, diff}
  logic [W+1:0] exp_q[$];

`ifdef BCD_SUB_INVALID_CHECK_EN
  localparam logic INV_ERR = 1'b1;
`else
  localparam logic INV_ERR = 1'b0;
`endif

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model: decimal arithmetic, ten's complement on underflow
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    int r;
    logic nb;
    r = bcd2int(ma) - bcd2int(mb) - int'(mbin);
    nb = (r < 0);
    if (nb) r = r + 10 ** DIGITS;
    return {1'b0, nb, int2bcd(r)};
  endfunction

  // driver tasks
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [W+1:0] e);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(cyc - start_cyc), 32'(DIGITS + 1));
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    start_op(ta, tb_, tbin, model(ta, tb_, tbin));
    wait_done();
  endtask

  // scoreboard: compare on every done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse_width", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("bout", 32'(bout), 32'(e[W]));
        check("err", 32'(err), 32'(e[W+1]));
      end
    end
    prev_done = done;
  end

  initial begin
    int dcount;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // rst and start together: start dropped
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_start_idle", 32'(busy), 32'd0);

    // basic op with latency, busy length and hold
    op(16'h1234, 16'h0567, 1'b0);
    check("busy_cycles", 32'(busy_cnt), 32'(DIGITS + 1));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("hold_diff", 32'(diff), 32'h0667);
    check("hold_bout", 32'(bout), 32'd0);

    op(16'h0003, 16'h0005, 1'b0);
    op(16'h1000, 16'h0000, 1'b1);
    op(16'h0000, 16'h0000, 1'b1);

    // start during RUN ignored, then back-to-back start from IDLE
    start_op(16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0));
    @(negedge clk);
    a = 16'h9999; b = 16'h8888; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    op(16'h0500, 16'h0499, 1'b0);

    // reset mid-RUN aborts
    start_op(16'h5555, 16'h1111, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    op(16'h9999, 16'h0001, 1'b0);

    // invalid digit: per-digit arithmetic unchanged, err only when checking is built in
    start_op(16'h00A0, 16'h0000, 1'b0, {INV_ERR, 1'b0, 16'h00A0});
    wait_done();
    op(16'h0042, 16'h0041, 1'b0);

    // random valid operands
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      op(ra, rb, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
